// File: rtl/ind_pkg.sv
// Shared definitions for the indicator sequence generator and decoder.
package ind_pkg;

  localparam int IND_W = 3;

  typedef logic [IND_W-1:0] ind_t;

  // Code emitted at each sequence index; element [0] is index 0.
  localparam logic [7:0][IND_W-1:0] IND_CODE = {
    3'b110, 3'b011, 3'b001, 3'b101, 3'b100, 3'b111, 3'b010, 3'b000
  };

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

endpackage

// File: rtl/ind_code_inv.sv
// Combinational inverse of the indicator code table: code -> sequence index.
module ind_code_inv
  import ind_pkg::*;
(
  input  logic [IND_W-1:0] code,
  output logic [IND_W-1:0] idx
);

  // All 8 codes appear in the table, so every input hits exactly one entry.
  always_comb begin
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (code == IND_CODE[i]) idx = IND_W'(i);
    end
  end

endmodule

// File: rtl/ind_seq_decoder.sv
// Indicator sequence decoder: decodes codes to indices, locks onto the
// running sequence, flywheels over single glitches and counts errors.
module ind_seq_decoder
  import ind_pkg::*;
#(
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 3,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IND_W-1:0] ind_in,
  input  logic             in_vld,
  input  logic             err_clr,
  output logic [IND_W-1:0] idx_out,
  output logic             idx_vld,
  output logic             locked,
  output logic             seq_err,
  output logic             wrap,
  output logic [ERR_W-1:0] err_cnt
);

  localparam logic [3:0] LOCK_TH = 4'(LOCK_CNT);
  localparam logic [3:0] LOSS_TH = 4'(LOSS_CNT);

  state_t           state;
  logic [IND_W-1:0] prev_idx;
  logic [3:0]       run;
  logic [3:0]       miss;

  logic [IND_W-1:0] idx;
  logic [IND_W-1:0] exp_idx;
  logic             match;
  logic [3:0]       run_inc;
  logic [3:0]       miss_inc;
  logic             err_inc;

  ind_code_inv u_inv (
    .code (ind_in),
    .idx  (idx)
  );

  assign exp_idx  = prev_idx + 1'b1;
  assign match    = (idx == exp_idx);
  assign run_inc  = run + 4'd1;
  assign miss_inc = miss + 4'd1;
  assign err_inc  = in_vld && (state == LOCKED) && !match;

  // Sequence FSM with registered index/status outputs; all holds when in_vld=0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= HUNT;
      prev_idx <= '0;
      run      <= '0;
      miss     <= '0;
      idx_out  <= '0;
      idx_vld  <= 1'b0;
      locked   <= 1'b0;
      seq_err  <= 1'b0;
      wrap     <= 1'b0;
    end else begin
      idx_vld <= 1'b0;
      seq_err <= 1'b0;
      wrap    <= 1'b0;
      if (in_vld) begin
        idx_out <= idx;
        idx_vld <= 1'b1;
        unique case (state)
          HUNT: begin
            prev_idx <= idx;
            run      <= '0;
            state    <= CHECK;
            locked   <= 1'b0;
          end
          CHECK: begin
            prev_idx <= idx;
            if (match) begin
              run <= run_inc;
              if (run_inc == LOCK_TH) begin
                state  <= LOCKED;
                locked <= 1'b1;
                miss   <= '0;
              end
            end else begin
              run <= '0;
            end
          end
          LOCKED: begin
            if (match) begin
              miss     <= '0;
              prev_idx <= idx;
              wrap     <= (idx == '0);
            end else begin
              seq_err <= 1'b1;
              if (miss_inc == LOSS_TH) begin
                // Too many misses in a row: resync on the current sample.
                state    <= CHECK;
                locked   <= 1'b0;
                prev_idx <= idx;
                run      <= '0;
                miss     <= '0;
              end else begin
                // Flywheel: assume the symbol was corrupted and advance.
                miss     <= miss_inc;
                prev_idx <= exp_idx;
              end
            end
          end
          default: begin
            state  <= HUNT;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

  // Saturating error counter; a clear beats a simultaneous increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_cnt <= '0;
    end else if (err_clr) begin
      err_cnt <= '0;
    end else if (err_inc && !(&err_cnt)) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule
